// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: byte width, idle/alignment COMMA and RX alignment states.
`timescale 1ns/1ps
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;
endpackage

// File: rtl/phy_rx_lane_deser.sv
// One RX lane: hunts for COMMA bit-by-bit, confirms LOCK_COUNT aligned COMMAs,
// then emits one registered byte per 8 clk_8f cycles.
`timescale 1ns/1ps
module phy_rx_lane_deser
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_BYTE,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_inS,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_stb,
  output logic              active
);

  localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        bc_cnt_q, bc_cnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              stb_q, stb_d;
  logic              active_q, active_d;

  logic is_comma, boundary;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    sr_d      = {sr_q[BYTE_W-2:0], data_inS};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    stb_d     = 1'b0;
    active_d  = active_q;
    is_comma  = (sr_d == COMMA);
    boundary  = (bit_cnt_q == 3'd7);

    case (state_q)
      SEARCH: begin
        // The COMMA's LSB lands this edge, so the next bit starts a fresh byte.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == LOCK_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // False lock: resume the hunt from the next bit.
            state_d  = SEARCH;
            bc_cnt_d = 4'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = sr_d;
          valid_d = !is_comma;
          stb_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx_lane_deser.sv
// Directed bench for the RX lane deserializer: table-driven byte vectors plus reset/lock corner sequences.
`timescale 1ns/1ps
module tb_phy_rx_lane_deser;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       din0, din1;
  logic [7:0] dout0, dout1;
  logic       vld0, vld1, stb0, stb1, act0, act1;

  int checks = 0;
  int errors = 0;

  always #1 clk_8f = ~clk_8f;

  phy_rx_lane_deser #(.COMMA(8'hBC), .LOCK_COUNT(4)) u_lane0 (
    .clk_8f(clk_8f), .reset(reset), .data_inS(din0),
    .data_out(dout0), .valid_out(vld0), .byte_stb(stb0), .active(act0)
  );

  phy_rx_lane_deser #(.COMMA(8'hBC), .LOCK_COUNT(1)) u_lane1 (
    .clk_8f(clk_8f), .reset(reset), .data_inS(din1),
    .data_out(dout1), .valid_out(vld1), .byte_stb(stb1), .active(act1)
  );

  typedef struct {
    logic [7:0] tx;
    logic       act;
    logic       stb;
    logic [7:0] data;
    logic       vld;
  } vec_t;

  vec_t tbl[$];

  // Recovered-payload scoreboard for lane 0
  logic       mon_en = 1'b1;
  int         stb_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_pay[6] = '{8'hA5, 8'h3C, 8'h24, 8'h66, 8'h42, 8'h99};

  always @(negedge clk_8f) begin
    if (mon_en && stb0 === 1'b1) begin
      stb_cnt++;
      if (vld0) got_q.push_back(dout0);
    end
  end

  function automatic vec_t mk(input logic [7:0] tx, input logic act, input logic stb,
                              input logic [7:0] data, input logic vld);
    vec_t v;
    v.tx = tx; v.act = act; v.stb = stb; v.data = data; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input int lane, input logic b);
    if (lane == 0) din0 = b;
    else           din1 = b;
    @(posedge clk_8f);
    #0.5;
  endtask

  task automatic send_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(lane, b[i]);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_byte(0, tbl[i].tx);
      chk($sformatf("vec%0d active", i), {31'd0, act0}, {31'd0, tbl[i].act});
      chk($sformatf("vec%0d byte_stb", i), {31'd0, stb0}, {31'd0, tbl[i].stb});
      if (tbl[i].stb) begin
        chk($sformatf("vec%0d data_out", i), {24'd0, dout0}, {24'd0, tbl[i].data});
        chk($sformatf("vec%0d valid_out", i), {31'd0, vld0}, {31'd0, tbl[i].vld});
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    send_bit(0, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    // 0-8: lock on 4 COMMAs, then payload/idle mix
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'hA5, 1, 1, 8'hA5, 1));
    tbl.push_back(mk(8'h3C, 1, 1, 8'h3C, 1));
    tbl.push_back(mk(8'hBC, 1, 1, 8'hBC, 0));
    tbl.push_back(mk(8'h24, 1, 1, 8'h24, 1));
    tbl.push_back(mk(8'hBC, 1, 1, 8'hBC, 0));
    // 9-16: false lock broken by 81, then relock on 4 fresh COMMAs
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'h81, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'h66, 1, 1, 8'h66, 1));
    // 17: payload before mid-byte reset
    tbl.push_back(mk(8'h42, 1, 1, 8'h42, 1));
    // 18-22: relock after reset needs 4 COMMAs
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hBC, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'h99, 1, 1, 8'h99, 1));

    din0 = 1'b0;
    din1 = 1'b0;
    reset = 1'b1;

    // Reset held while data toggles
    for (int c = 0; c < 3; c++) begin
      send_bit(0, c[0] ^ 1'b1);
      chk("rst data_out", {24'd0, dout0}, 32'd0);
      chk("rst valid_out", {31'd0, vld0}, 32'd0);
      chk("rst byte_stb", {31'd0, stb0}, 32'd0);
      chk("rst active", {31'd0, act0}, 32'd0);
      chk("rst lane1 active", {31'd0, act1}, 32'd0);
    end
    reset = 1'b0;

    // Junk bits ahead of the first COMMA
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    chk("junk active", {31'd0, act0}, 32'd0);
    run_range(0, 8);

    // False lock, fall back, relock
    pulse_reset();
    chk("rst2 active", {31'd0, act0}, 32'd0);
    run_range(9, 16);

    // Mid-payload reset
    run_range(17, 17);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    chk("midbyte byte_stb", {31'd0, stb0}, 32'd0);
    pulse_reset();
    chk("midrst active", {31'd0, act0}, 32'd0);
    chk("midrst valid_out", {31'd0, vld0}, 32'd0);
    chk("midrst data_out", {24'd0, dout0}, 32'd0);
    run_range(18, 22);

    // Let the monitor capture the last strobe before freezing the scoreboard
    @(negedge clk_8f);
    #0.1;
    mon_en = 1'b0;

    // LOCK_COUNT=1 lane: one COMMA locks immediately
    send_byte(1, 8'hBC);
    chk("lc1 active", {31'd0, act1}, 32'd1);
    chk("lc1 comma byte_stb", {31'd0, stb1}, 32'd0);
    send_byte(1, 8'h5A);
    chk("lc1 byte_stb", {31'd0, stb1}, 32'd1);
    chk("lc1 data_out", {24'd0, dout1}, 32'h5A);
    chk("lc1 valid_out", {31'd0, vld1}, 32'd1);
    send_bit(1, 1'b0);
    chk("lc1 stb one-cycle", {31'd0, stb1}, 32'd0);
    chk("lc1 data held", {24'd0, dout1}, 32'h5A);

    // Scoreboard: strobe count and recovered payload bytes (81 and E7 never appear)
    chk("lane0 strobe count", stb_cnt, 32'd8);
    chk("lane0 payload count", got_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("payload[%0d]", i),
          (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF,
          {24'd0, exp_pay[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
